// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: interrupt FSM state type, pin-count limit and the
// irq_id width derivation used by gpio_irq_ctrl.
package gpio_pkg;

    localparam int GPIO_MAX_PINS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } irq_state_t;

    // A single pin still needs a one-bit id so the port never collapses to zero width
    function automatic int calc_idw(input int npins);
        return (npins > 1) ? $clog2(npins) : 1;
    endfunction

endpackage

// File: rtl/edge_detector.sv
// Registered rising/falling edge detector. Each pulse is one cycle long and
// appears the cycle after the new level is sampled.
module edge_detector #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] pos_edge,
    output logic [WIDTH-1:0] neg_edge
);

    logic [WIDTH-1:0] history;

    // History starts at 0, so a line held high out of reset reports one rise
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            history  <= '0;
            pos_edge <= '0;
            neg_edge <= '0;
        end else begin
            history  <= sig_in;
            pos_edge <= sig_in & ~history;
            neg_edge <= ~sig_in & history;
        end
    end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Per-pin GPIO interrupt controller: sticky edge-pending bits arbitrated onto one
// request with lowest-index priority. Define GPIO_IRQ_SYNC_EN to add a 2-flop pin synchronizer.
module gpio_irq_ctrl
    import gpio_pkg::*;
#(
    parameter  int NPINS = 8,
    localparam int IDW   = calc_idw(NPINS)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [NPINS-1:0] pin_in,
    input  logic [NPINS-1:0] mode_rise,
    input  logic [NPINS-1:0] mode_fall,
    input  logic [NPINS-1:0] irq_en,
    input  logic             clr_valid,
    input  logic [NPINS-1:0] clr_mask,
    output logic [NPINS-1:0] pending,
    output logic             irq_req,
    output logic [IDW-1:0]   irq_id,
    input  logic             irq_ack
);

    irq_state_t       state, next_state;
    logic [NPINS-1:0] pin_s;
    logic [NPINS-1:0] pos_edge, neg_edge;
    logic [NPINS-1:0] hit, clr, ack_clr, eligible;
    logic [NPINS-1:0] pending_q;
    logic [IDW-1:0]   winner, irq_id_q, irq_id_d;
    logic             irq_req_q, irq_req_d;

    // Scanning downwards lets the lowest set index overwrite the rest
    function automatic logic [IDW-1:0] lowest_index(input logic [NPINS-1:0] vec);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = NPINS - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDW'(i);
        end
        return idx;
    endfunction

`ifdef GPIO_IRQ_SYNC_EN
    for (genvar g = 0; g < NPINS; g++) begin : g_sync
        logic [1:0] sync_ff;
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) sync_ff <= 2'b00;
            else        sync_ff <= {sync_ff[0], pin_in[g]};
        end
        assign pin_s[g] = sync_ff[1];
    end
`else
    assign pin_s = pin_in;
`endif

    edge_detector #(.WIDTH(NPINS)) u_edge (
        .clk      (clk),
        .n_rst    (n_rst),
        .sig_in   (pin_s),
        .pos_edge (pos_edge),
        .neg_edge (neg_edge)
    );

    always_comb begin
        hit     = (pos_edge & mode_rise) | (neg_edge & mode_fall);
        ack_clr = '0;
        if (state == REQ && irq_ack) ack_clr[irq_id_q] = 1'b1;
        clr      = ({NPINS{clr_valid}} & clr_mask) | ack_clr;
        eligible = pending_q & irq_en;
        winner   = lowest_index(eligible);
    end

    // A new edge on the same cycle as a clear keeps the pin pending
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) pending_q <= '0;
        else        pending_q <= hit | (pending_q & ~clr);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            irq_req_q <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            state     <= next_state;
            irq_req_q <= irq_req_d;
            irq_id_q  <= irq_id_d;
        end
    end

    // Ack outranks withdrawal; GAP forces one low cycle between requests
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (eligible != '0) next_state = REQ;
            REQ: begin
                if (irq_ack)                  next_state = GAP;
                else if (!eligible[irq_id_q]) next_state = IDLE;
            end
            GAP:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        irq_req_d = (next_state == REQ);
        irq_id_d  = irq_id_q;
        if (state == IDLE && eligible != '0) irq_id_d = winner;
    end

    assign pending = pending_q;
    assign irq_req = irq_req_q;
    assign irq_id  = irq_id_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl: directed scenarios plus randomized traffic
// against a cycle-level reference model of the pending/arbitration rules.
module tb_gpio_irq_ctrl;

`ifdef GPIO_IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] pin_in = '0, mode_rise = '0, mode_fall = '0, irq_en = '0, clr_mask = '0;
    logic       clr_valid = 1'b0, irq_ack = 1'b0;
    logic [7:0] pending;
    logic       irq_req;
    logic [2:0] irq_id;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit [7:0] m_pend;
    bit       m_req;
    int       m_id;
    int       m_phase;
    bit [7:0] hist [4];

    gpio_irq_ctrl #(.NPINS(8)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .pin_in    (pin_in),
        .mode_rise (mode_rise),
        .mode_fall (mode_fall),
        .irq_en    (irq_en),
        .clr_valid (clr_valid),
        .clr_mask  (clr_mask),
        .pending   (pending),
        .irq_req   (irq_req),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_req = 1'b0; m_id = 0; m_phase = 0;
        for (int i = 0; i < 4; i++) hist[i] = '0;
    endtask

    // Advance one clock and apply the controller's rules to the model
    task automatic step();
        bit [7:0] hit, elig, clrm;
        @(posedge clk);
        hit  = ((hist[LAT] & ~hist[LAT+1]) & mode_rise) | ((~hist[LAT] & hist[LAT+1]) & mode_fall);
        elig = m_pend & irq_en;
        clrm = clr_valid ? clr_mask : 8'h00;
        case (m_phase)
            0: if (elig != 0) begin m_phase = 1; m_id = lowest(elig); end
            1: begin
                if (irq_ack) begin clrm[m_id] = 1'b1; m_phase = 2; end
                else if (!elig[m_id]) m_phase = 0;
            end
            default: m_phase = 0;
        endcase
        m_pend = hit | (m_pend & ~clrm);
        m_req  = (m_phase == 1);
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = pin_in;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        n_rst = 1'b0;
        pin_in = '0; mode_rise = '0; mode_fall = '0; irq_en = '0;
        clr_valid = 1'b0; clr_mask = '0; irq_ack = 1'b0;
        model_reset();
        @(posedge clk); #2;
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        step(); step();
        checks++;
        if (pending !== 8'h00) begin errors++; $display("[TB] FAIL reset_pending: got %h expected 00", pending); end
        checks++;
        if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq_req: got %b expected 0", irq_req); end
        checks++;
        if (irq_id !== 3'd0) begin errors++; $display("[TB] FAIL reset_irq_id: got %0d expected 0", irq_id); end
    endtask

    task automatic test_latency();
        int n, p_at;
        do_reset();
        mode_rise = 8'h08; irq_en = 8'h08; pin_in = 8'h08;
        n = 0; p_at = -1;
        while (irq_req !== 1'b1 && n < 12) begin
            step(); n++;
            if (p_at < 0 && pending[3] === 1'b1) p_at = n;
        end
        checks++;
        if (p_at != 2 + LAT) begin errors++; $display("[TB] FAIL lat_pending: got %0d expected %0d", p_at, 2 + LAT); end
        checks++;
        if (n != 3 + LAT) begin errors++; $display("[TB] FAIL lat_irq_req: got %0d expected %0d", n, 3 + LAT); end
        checks++;
        if (irq_id !== 3'd3) begin errors++; $display("[TB] FAIL lat_irq_id: got %0d expected 3", irq_id); end
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        checks++;
        if (pending !== 8'h00 || irq_req !== 1'b0) begin errors++; $display("[TB] FAIL lat_ack: got pend=%h req=%b expected pend=00 req=0", pending, irq_req); end
        step();
        checks++;
        if (irq_req !== m_req || pending !== m_pend) begin errors++; $display("[TB] FAIL lat_after_gap: got req=%b pend=%h expected req=%b pend=%h", irq_req, pending, m_req, m_pend); end
    endtask

    task automatic test_priority();
        int n;
        do_reset();
        mode_rise = 8'h24; irq_en = 8'h24; pin_in = 8'h24;
        n = 0;
        while (irq_req !== 1'b1 && n < 12) begin step(); n++; end
        checks++;
        if (irq_req !== 1'b1 || irq_id !== 3'd2) begin errors++; $display("[TB] FAIL prio_first: got req=%b id=%0d expected req=1 id=2", irq_req, irq_id); end
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        checks++;
        if (pending !== 8'h20 || irq_req !== 1'b0) begin errors++; $display("[TB] FAIL prio_gap: got pend=%h req=%b expected pend=20 req=0", pending, irq_req); end
        step(); step();
        checks++;
        if (irq_req !== 1'b1 || irq_id !== 3'd5) begin errors++; $display("[TB] FAIL prio_second: got req=%b id=%0d expected req=1 id=5", irq_req, irq_id); end
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        step(); step();
        checks++;
        if (irq_req !== 1'b0 || pending !== 8'h00) begin errors++; $display("[TB] FAIL prio_idle: got req=%b pend=%h expected req=0 pend=00", irq_req, pending); end
    endtask

    task automatic test_set_wins();
        int n;
        do_reset();
        mode_rise = 8'h02; mode_fall = 8'h02; pin_in = 8'h02;
        for (int i = 0; i < 2 + LAT; i++) step();
        pin_in = 8'h00;
        for (int i = 0; i < 1 + LAT; i++) step();
        clr_valid = 1'b1; clr_mask = 8'h02; step(); clr_valid = 1'b0; clr_mask = '0;
        checks++;
        if (pending[1] !== 1'b1 || pending !== m_pend) begin errors++; $display("[TB] FAIL setwins_clr: got %h expected %h", pending, m_pend); end
        irq_en = 8'h02;
        n = 0;
        while (irq_req !== 1'b1 && n < 12) begin step(); n++; end
        pin_in = 8'h02;
        for (int i = 0; i < 1 + LAT; i++) step();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        checks++;
        if (pending[1] !== 1'b1 || irq_req !== 1'b0) begin errors++; $display("[TB] FAIL setwins_ack: got pend=%h req=%b expected pend[1]=1 req=0", pending, irq_req); end
    endtask

    task automatic test_withdraw();
        int n;
        do_reset();
        mode_rise = 8'h10; irq_en = 8'h10; pin_in = 8'h10;
        n = 0;
        while (irq_req !== 1'b1 && n < 12) begin step(); n++; end
        irq_en = 8'h00; step();
        checks++;
        if (irq_req !== 1'b0 || pending[4] !== 1'b1) begin errors++; $display("[TB] FAIL withdraw: got req=%b pend=%h expected req=0 pend[4]=1", irq_req, pending); end
        irq_en = 8'h10; step();
        checks++;
        if (irq_req !== 1'b1 || irq_id !== 3'd4) begin errors++; $display("[TB] FAIL reissue: got req=%b id=%0d expected req=1 id=4", irq_req, irq_id); end
    endtask

    task automatic test_fall_modes();
        do_reset();
        mode_fall = 8'h01; irq_en = 8'h01; pin_in = 8'h01;
        for (int i = 0; i < 3 + LAT; i++) step();
        checks++;
        if (pending[0] !== 1'b0) begin errors++; $display("[TB] FAIL fall_ignore_rise: got %b expected 0", pending[0]); end
        pin_in = 8'h00;
        for (int i = 0; i < 2 + LAT; i++) step();
        checks++;
        if (pending[0] !== 1'b1) begin errors++; $display("[TB] FAIL fall_set: got %b expected 1", pending[0]); end
        mode_rise = 8'h40; mode_fall = 8'h41; pin_in = 8'h40;
        for (int i = 0; i < 2 + LAT; i++) step();
        checks++;
        if (pending[6] !== 1'b1) begin errors++; $display("[TB] FAIL both_rise: got %b expected 1", pending[6]); end
        pin_in = 8'h00;
        for (int i = 0; i < 2 + LAT; i++) step();
        checks++;
        if (pending[6] !== 1'b1 || pending !== m_pend) begin errors++; $display("[TB] FAIL both_fall: got %h expected %h", pending, m_pend); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            pin_in = 8'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                mode_rise = 8'($urandom); mode_fall = 8'($urandom); irq_en = 8'($urandom);
            end
            clr_valid = ($urandom_range(0, 7) == 0);
            clr_mask  = 8'($urandom);
            irq_ack   = ($urandom_range(0, 2) == 0);
            step();
            checks++;
            if (pending !== m_pend) begin errors++; $display("[TB] FAIL rand_pending c=%0d: got %h expected %h", c, pending, m_pend); end
            checks++;
            if (irq_req !== m_req) begin errors++; $display("[TB] FAIL rand_irq_req c=%0d: got %b expected %b", c, irq_req, m_req); end
            checks++;
            if (irq_id !== 3'(m_id)) begin errors++; $display("[TB] FAIL rand_irq_id c=%0d: got %0d expected %0d", c, irq_id, m_id); end
        end
        clr_valid = 1'b0; irq_ack = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        int n;
        do_reset();
        mode_rise = 8'h80; irq_en = 8'h80; pin_in = 8'h80;
        n = 0;
        while (irq_req !== 1'b1 && n < 12) begin step(); n++; end
        checks++;
        if (irq_req !== 1'b1 || irq_id !== 3'd7) begin errors++; $display("[TB] FAIL midreq_setup: got req=%b id=%0d expected req=1 id=7", irq_req, irq_id); end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (irq_req !== 1'b0 || pending !== 8'h00 || irq_id !== 3'd0) begin errors++; $display("[TB] FAIL midreq_reset: got req=%b pend=%h id=%0d expected all 0", irq_req, pending, irq_id); end
        do_reset();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_priority();
        test_set_wins();
        test_withdraw();
        test_fall_modes();
        test_random();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
